io_port_capture: RTL and testbench
==================================

// Module: io_port_capture
// PURPOSE
// Receive side of the parallel input port IO_P0 in bean_mc_top. Samples the asynchronous
// DATA_WIDTH-bit pin bus, synchronizes it, deglitches it and tracks the stable port value.
// Every accepted change is queued as an event in a small FIFO that the controller pops.
// Sits between the pad ring and the controller's port-read/interrupt logic.
// PARAMETERS
// DATA_WIDTH     8  width of pin bus and event data (matches `DATA_WIDTH)
// SYNC_STAGES    2  flops in the input synchronizer chain (>=2)
// STABLE_CYCLES  2  consecutive equal synchronized samples required to accept a value (>=1)
// FIFO_DEPTH     4  event FIFO entries, power of two (>=2)
// PORTS
// ref_clk    in   1                        single clock for all logic
// chip_rst   in   1                        synchronous reset, active-high
// pin_in     in   DATA_WIDTH               raw asynchronous pad input (IO_P0)
// port_val   out  DATA_WIDTH               current deglitched port value
// evt_valid  out  1                        FIFO non-empty; evt_data valid
// evt_data   out  DATA_WIDTH               oldest queued accepted value (show-ahead)
// evt_rd     in   1                        pop one event; ignored when evt_valid=0
// evt_count  out  $clog2(FIFO_DEPTH+1)     entries currently queued
// ovf        out  1                        sticky: an event was dropped because the FIFO was full
// ovf_clr    in   1                        clears ovf
// BEHAVIOUR
// - Reset (chip_rst=1 at a ref_clk edge): sync chain, candidate, counter, port_val = 0;
//   FIFO empty (evt_valid=0, evt_count=0, evt_data=0); ovf=0; FSM -> IDLE.
// - Synchronizer: sync_q = output of the last of SYNC_STAGES flops; no other logic reads pin_in.
// - Deglitch FSM, registers cand[DATA_WIDTH] and cnt:
//   IDLE: sync_q==port_val -> stay. sync_q!=port_val -> cand<=sync_q, cnt<=1, go PEND
//     (if STABLE_CYCLES==1, accept in the same cycle instead and stay IDLE).
//   PEND: sync_q==port_val -> IDLE, no event (glitch reverted).
//     sync_q!=cand (a third value) -> cand<=sync_q, cnt<=1, stay PEND.
//     sync_q==cand and cnt==STABLE_CYCLES-1 -> accept: port_val<=cand, push cand, go IDLE.
//     sync_q==cand otherwise -> cnt<=cnt+1.
// - Latency: a clean pin change that is held is seen on port_val, and is pushed,
//   SYNC_STAGES+STABLE_CYCLES edges after the first edge that samples it. evt_valid
//   rises on the same edge when the FIFO was empty.
// - Pulses shorter than STABLE_CYCLES synchronized cycles produce no event and do not change port_val.
// - FIFO: show-ahead. evt_data = head entry. evt_rd with evt_valid=1 pops on that edge.
//   Push and pop in one cycle: both happen, count unchanged, valid even when full.
//   Push while full with no pop: the new value is dropped, ovf<=1, and port_val still updates.
//   Pointers wrap modulo FIFO_DEPTH. evt_rd while empty: no effect, no underflow flag.
// - ovf: set has priority over ovf_clr in the same cycle. Otherwise ovf_clr clears it.
// - Reset mid-operation: pending candidate and all queued events are discarded.
//   A pin held non-zero across reset is re-detected as a change from 0 after release.
// TESTING
// 1 Reset, pin_in=8'h00 held 20 cycles -> port_val=00, evt_valid=0, evt_count=0, ovf=0.
// 2 Reset release, then pin_in 00->81 held (counter case) -> port_val=81 and evt_data=81 with
//   evt_valid=1 exactly 4 edges after the first sampling edge. evt_rd=1 for one cycle -> evt_valid=0.
// 3 pin_in=00, then pulse to 55 for 1 cycle -> no event, port_val stays 00.
//   Hold 55 for 3 cycles -> one event, 55.
// 4 Five held changes 01,02,03,04,05 with no reads -> evt_count=4, ovf=1, pops return 01..04,
//   port_val=05. ovf_clr -> ovf=0.
// 5 FIFO full, push accepted on the same edge as evt_rd -> count stays 4, ovf stays 0, order preserved.
// 6 chip_rst asserted with 2 queued events and PEND active -> FIFO empty, port_val=00.
//   With pin_in=81 held, one event 81 follows after release.

Source files
------------

// File: rtl/io_port_capture_if.sv
// Pin-side and controller-side signal bundle of the IO_P0 input capture block.
// The slave modport is the capture block; the master modport is whatever drives pins and pops events.
interface io_port_capture_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] pin_in;
  logic [DATA_WIDTH-1:0] port_val;
  logic                  evt_valid;
  logic [DATA_WIDTH-1:0] evt_data;
  logic                  evt_rd;
  logic [CW-1:0]         evt_count;
  logic                  ovf;
  logic                  ovf_clr;

  modport master (
    output pin_in, evt_rd, ovf_clr,
    input  port_val, evt_valid, evt_data, evt_count, ovf
  );

  modport slave (
    input  pin_in, evt_rd, ovf_clr,
    output port_val, evt_valid, evt_data, evt_count, ovf
  );
endinterface

// File: rtl/io_port_capture.sv
// IO_P0 receive path: synchronizer, deglitch FSM tracking the stable port value,
// and a show-ahead event FIFO of accepted changes with a sticky overflow flag.
module io_port_capture #(
  parameter int DATA_WIDTH    = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input logic              ref_clk,
  input logic              chip_rst,
  io_port_capture_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_s;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] cand_q, cand_d;
  logic [NW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] port_val_q, port_val_d;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;

  logic                  push_s;
  logic [DATA_WIDTH-1:0] push_data_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  push_ok_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchronizer shift chain; only stage 0 looks at the pad.
  always_comb begin
    sync_d[0] = bus.pin_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Deglitch FSM: a new value must persist STABLE_CYCLES samples before it is accepted.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    port_val_d  = port_val_q;
    push_s      = 1'b0;
    push_data_s = cand_q;
    case (state_q)
      IDLE: begin
        if (sync_s != port_val_q) begin
          if (STABLE_CYCLES == 1) begin
            port_val_d  = sync_s;
            push_s      = 1'b1;
            push_data_s = sync_s;
          end else begin
            cand_d  = sync_s;
            cnt_d   = NW'(1);
            state_d = PEND;
          end
        end else begin
          state_d = IDLE;
        end
      end
      PEND: begin
        if (sync_s == port_val_q) begin
          state_d = IDLE;
        end else if (sync_s != cand_q) begin
          cand_d = sync_s;
          cnt_d  = NW'(1);
        end else if (cnt_q == NW'(STABLE_CYCLES - 1)) begin
          port_val_d = cand_q;
          push_s     = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + NW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Event FIFO; a pop on the same edge frees the slot a full-FIFO push needs.
  always_comb begin
    pop_s     = bus.evt_rd && (count_q != CW'(0));
    full_s    = (count_q == CW'(FIFO_DEPTH));
    push_ok_s = push_s && (!full_s || pop_s);
    mem_d     = mem_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data_s;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push_s && full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge ref_clk) begin
    if (chip_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      state_q    <= IDLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      port_val_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      mem_q      <= mem_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      port_val_q <= port_val_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.port_val  = port_val_q;
  assign bus.evt_valid = (count_q != CW'(0));
  assign bus.evt_data  = mem_q[rd_ptr_q];
  assign bus.evt_count = count_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_io_port_capture.sv
// Bench for io_port_capture: directed vector table, hand-written FIFO/reset sequences and
// random stimulus, all checked against a run-length/queue reference model.
module tb_io_port_capture;
  localparam int DW = 8;
  localparam int SS = 2;
  localparam int SC = 2;
  localparam int FD = 4;

  logic ref_clk = 1'b0;
  logic chip_rst;

  io_port_capture_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();

  io_port_capture #(
    .DATA_WIDTH(DW), .SYNC_STAGES(SS), .STABLE_CYCLES(SC), .FIFO_DEPTH(FD)
  ) dut (
    .ref_clk (ref_clk),
    .chip_rst(chip_rst),
    .bus     (bus)
  );

  always #5 ref_clk = ~ref_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pin delay line, run length of the synchronized value, event queue.
  logic [DW-1:0] m_sync [SS];
  logic [DW-1:0] m_last;
  int            m_run;
  logic [DW-1:0] m_pv;
  logic [DW-1:0] m_q [$];
  bit            m_ovf;

  typedef struct {
    logic [DW-1:0] pin;
    bit            rd;
    bit            rst;
    logic [DW-1:0] pv;
    bit            valid;
    int            cnt;
    logic [DW-1:0] data;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic [DW-1:0] pin, input bit rd, input bit clr, input bit rst);
    logic [DW-1:0] s;
    bit push, pop, full;
    if (rst) begin
      for (int i = 0; i < SS; i++) m_sync[i] = '0;
      m_last = '0;
      m_run  = 0;
      m_pv   = '0;
      m_q.delete();
      m_ovf  = 1'b0;
      return;
    end
    s = m_sync[SS-1];
    if (s == m_last) m_run++;
    else begin
      m_last = s;
      m_run  = 1;
    end
    push = 1'b0;
    if (s != m_pv && m_run >= SC) begin
      m_pv = s;
      push = 1'b1;
    end
    pop  = rd && (m_q.size() > 0);
    full = (m_q.size() == FD);
    if (pop) void'(m_q.pop_front());
    if (push && (!full || pop)) m_q.push_back(s);
    if (push && full && !pop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = pin;
  endtask

  task automatic step(input logic [DW-1:0] pin, input bit rd, input bit clr, input bit rst);
    @(negedge ref_clk);
    bus.pin_in  = pin;
    bus.evt_rd  = rd;
    bus.ovf_clr = clr;
    chip_rst    = rst;
    @(posedge ref_clk);
    model_edge(pin, rd, clr, rst);
    #1;
    check("model.port_val", int'(bus.port_val), int'(m_pv));
    check("model.evt_valid", int'(bus.evt_valid), int'(m_q.size() > 0));
    check("model.evt_count", int'(bus.evt_count), m_q.size());
    check("model.ovf", int'(bus.ovf), int'(m_ovf));
    if (m_q.size() > 0) check("model.evt_data", int'(bus.evt_data), int'(m_q[0]));
    else if (rst) check("model.evt_data_rst", int'(bus.evt_data), 0);
  endtask

  task automatic hold(input logic [DW-1:0] pin, input int n);
    repeat (n) step(pin, 1'b0, 1'b0, 1'b0);
  endtask

  vec_t tbl [21];

  initial begin
    bus.pin_in  = '0;
    bus.evt_rd  = 1'b0;
    bus.ovf_clr = 1'b0;
    chip_rst    = 1'b1;

    tbl = '{
      '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 0, 8'h00},
      '{8'h81, 1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00},
      '{8'h81, 1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00},
      '{8'h81, 1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00},
      '{8'h81, 1'b0, 1'b0, 8'h81, 1'b1, 1, 8'h81},
      '{8'h81, 1'b1, 1'b0, 8'h81, 1'b0, 0, 8'h00},
      '{8'h00, 1'b0, 1'b0, 8'h81, 1'b0, 0, 8'h00},
      '{8'h00, 1'b0, 1'b0, 8'h81, 1'b0, 0, 8'h00},
      '{8'h00, 1'b0, 1'b0, 8'h81, 1'b0, 0, 8'h00},
      '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1, 8'h00},
      '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 0, 8'h00},
      '{8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00},
      '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00},
      '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00},
      '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00},
      '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00},
      '{8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00},
      '{8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00},
      '{8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00},
      '{8'h55, 1'b0, 1'b0, 8'h55, 1'b1, 1, 8'h55},
      '{8'h55, 1'b1, 1'b0, 8'h55, 1'b0, 0, 8'h00}
    };

    // Reset, then quiet pins.
    step(8'h00, 1'b0, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    hold(8'h00, 20);
    check("idle.port_val", int'(bus.port_val), 8'h00);
    check("idle.evt_valid", int'(bus.evt_valid), 0);
    check("idle.evt_count", int'(bus.evt_count), 0);
    check("idle.ovf", int'(bus.ovf), 0);

    // Latency, pop, glitch rejection and a held change.
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].pin, tbl[i].rd, 1'b0, tbl[i].rst);
      check($sformatf("vec%0d.port_val", i), int'(bus.port_val), int'(tbl[i].pv));
      check($sformatf("vec%0d.evt_valid", i), int'(bus.evt_valid), int'(tbl[i].valid));
      check($sformatf("vec%0d.evt_count", i), int'(bus.evt_count), tbl[i].cnt);
      if (tbl[i].valid || tbl[i].rst)
        check($sformatf("vec%0d.evt_data", i), int'(bus.evt_data), int'(tbl[i].data));
    end

    // Overflow: five events into a four-deep FIFO.
    for (int v = 1; v <= 5; v++) hold(DW'(v), 6);
    check("ovf.count", int'(bus.evt_count), 4);
    check("ovf.flag", int'(bus.ovf), 1);
    check("ovf.port_val", int'(bus.port_val), 8'h05);
    for (int v = 1; v <= 4; v++) begin
      check($sformatf("ovf.pop%0d", v), int'(bus.evt_data), v);
      step(8'h05, 1'b1, 1'b0, 1'b0);
    end
    check("ovf.drained", int'(bus.evt_valid), 0);
    step(8'h05, 1'b0, 1'b1, 1'b0);
    check("ovf.cleared", int'(bus.ovf), 0);

    // Full FIFO, push coinciding with a pop.
    for (int v = 8'h11; v <= 8'h14; v++) hold(DW'(v), 6);
    check("fullpp.pre_count", int'(bus.evt_count), 4);
    hold(8'h15, 3);
    step(8'h15, 1'b1, 1'b0, 1'b0);
    check("fullpp.count", int'(bus.evt_count), 4);
    check("fullpp.ovf", int'(bus.ovf), 0);
    check("fullpp.port_val", int'(bus.port_val), 8'h15);
    for (int v = 8'h12; v <= 8'h15; v++) begin
      check($sformatf("fullpp.pop%0h", v), int'(bus.evt_data), v);
      step(8'h15, 1'b1, 1'b0, 1'b0);
    end
    check("fullpp.drained", int'(bus.evt_count), 0);

    // Reset with queued events and a pending candidate.
    hold(8'h21, 6);
    hold(8'h22, 6);
    check("rst.pre_count", int'(bus.evt_count), 2);
    hold(8'h81, 3);
    step(8'h81, 1'b0, 1'b0, 1'b1);
    check("rst.count", int'(bus.evt_count), 0);
    check("rst.valid", int'(bus.evt_valid), 0);
    check("rst.port_val", int'(bus.port_val), 8'h00);
    hold(8'h81, 3);
    check("rst.not_yet", int'(bus.port_val), 8'h00);
    hold(8'h81, 1);
    check("rst.port_val_after", int'(bus.port_val), 8'h81);
    check("rst.count_after", int'(bus.evt_count), 1);
    check("rst.data_after", int'(bus.evt_data), 8'h81);

    // Random pin runs, reads, clears and rare resets against the model.
    for (int n = 0; n < 60; n++) begin
      logic [DW-1:0] v;
      int len;
      case ($urandom_range(0, 3))
        0:       v = 8'h00;
        1:       v = 8'h81;
        2:       v = 8'h55;
        default: v = DW'($urandom);
      endcase
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++)
        step(v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
